// File: rtl/mem_access_arbiter_pkg.sv
// Shared defaults for the memory access subsystem.
//   DEF_WIDTH  : data word width
//   DEF_LENGTH : number of memory words
//   DEF_N_REQ  : number of requesters
//   wrap_inc   : modulo-n increment used for the round-robin pointer
package mem_access_arbiter_pkg;
   localparam int DEF_WIDTH  = 32;
   localparam int DEF_LENGTH = 10;
   localparam int DEF_N_REQ  = 2;

   function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
      return (idx + 1 == n) ? 0 : idx + 1;
   endfunction
endpackage

// File: rtl/mem_access_arbiter_if.sv
// Requester / response / memory-port bundle of the access arbiter.
//   req_valid/req_write/req_addr/req_wdata : packed per-requester requests
//   req_ready  : one-hot grant
//   resp_valid/resp_rdata/resp_err : registered read response
//   mem_w_*    : memory write port, mem_r_addr/mem_r_data : combinational read port
// Modports: slave = arbiter side, master = requester/memory side.
interface mem_access_arbiter_if
   import mem_access_arbiter_pkg::*;
#(
   parameter int width     = DEF_WIDTH,
   parameter int length    = DEF_LENGTH,
   parameter int n_req     = DEF_N_REQ,
   parameter int addr_size = $clog2(length)
);
   logic [n_req-1:0]           req_valid;
   logic [n_req-1:0]           req_write;
   logic [n_req*addr_size-1:0] req_addr;
   logic [n_req*width-1:0]     req_wdata;
   logic [n_req-1:0]           req_ready;
   logic [n_req-1:0]           resp_valid;
   logic [width-1:0]           resp_rdata;
   logic                       resp_err;
   logic                       mem_w_enable;
   logic [addr_size-1:0]       mem_w_addr;
   logic [width-1:0]           mem_w_data;
   logic [addr_size-1:0]       mem_r_addr;
   logic [width-1:0]           mem_r_data;

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata, mem_r_data,
      output req_ready, resp_valid, resp_rdata, resp_err,
             mem_w_enable, mem_w_addr, mem_w_data, mem_r_addr
   );

   modport master (
      output req_valid, req_write, req_addr, req_wdata, mem_r_data,
      input  req_ready, resp_valid, resp_rdata, resp_err,
             mem_w_enable, mem_w_addr, mem_w_data, mem_r_addr
   );
endinterface

// File: rtl/mem_access_arbiter_rr_grant.sv
// Combinational round-robin picker.
//   i_valid : request vector
//   i_ptr   : highest-priority index this cycle
//   o_grant : one-hot winner, o_idx : winner index, o_any : some request valid
module rr_grant
   import mem_access_arbiter_pkg::*;
#(
   parameter int N  = DEF_N_REQ,
   parameter int PW = $clog2(N)
) (
   input  logic [N-1:0]  i_valid,
   input  logic [PW-1:0] i_ptr,
   output logic [N-1:0]  o_grant,
   output logic [PW-1:0] o_idx,
   output logic          o_any
);
   logic [N-1:0] w_shift;
   int unsigned  w_cand;

   // Scan from i_ptr upward modulo N; the first valid requester wins.
   always_comb begin
      o_grant = '0;
      o_idx   = '0;
      o_any   = 1'b0;
      w_shift = '0;
      w_cand  = 0;
      for (int unsigned k = 0; k < N; k++) begin
         w_cand  = (32'(i_ptr) + k) % N;
         w_shift = i_valid >> w_cand;
         if (!o_any && w_shift[0]) begin
            o_any   = 1'b1;
            o_idx   = PW'(w_cand);
            o_grant = N'(1) << w_cand;
         end
      end
   end
endmodule

// File: rtl/mem_access_arbiter.sv
// Round-robin access controller sharing one external memory among n_req
// requesters: one read or write granted per cycle, read data returned one
// cycle later on a registered response bus.
//   clk   : clock (rising edge)
//   rst_n : synchronous active-low reset
//   bus   : request/response/memory bundle (slave side)
module mem_access_arbiter
   import mem_access_arbiter_pkg::*;
#(
   parameter int width     = DEF_WIDTH,
   parameter int length    = DEF_LENGTH,
   parameter int n_req     = DEF_N_REQ,
   parameter int addr_size = $clog2(length)
) (
   input logic                  clk,
   input logic                  rst_n,
   mem_access_arbiter_if.slave  bus
);
   localparam int PW = (n_req > 1) ? $clog2(n_req) : 1;

   logic [PW-1:0]        r_rr_ptr;
   logic [n_req-1:0]     r_resp_valid;
   logic [width-1:0]     r_resp_rdata;
   logic                 r_resp_err;

   logic [n_req-1:0]     w_grant;
   logic [PW-1:0]        w_idx;
   logic                 w_any;
   logic                 w_go;
   logic                 w_write;
   logic                 w_in_range;
   logic                 w_wen;
   logic                 w_ren;
   logic [addr_size-1:0] w_addr;
   logic [width-1:0]     w_wdata;

   rr_grant #(.N(n_req), .PW(PW)) u_rr_grant (
      .i_valid (bus.req_valid),
      .i_ptr   (r_rr_ptr),
      .o_grant (w_grant),
      .o_idx   (w_idx),
      .o_any   (w_any)
   );

   always_comb begin
      w_addr     = bus.req_addr[int'(w_idx)*addr_size +: addr_size];
      w_wdata    = bus.req_wdata[int'(w_idx)*width +: width];
      w_write    = bus.req_write[w_idx];
      // Extra bit keeps the compare correct when length == 2**addr_size.
      w_in_range = {1'b0, w_addr} < (addr_size+1)'(length);
      w_go       = w_any & rst_n;
      w_wen      = w_go & w_write & w_in_range;
      w_ren      = w_go & ~w_write & w_in_range;
   end

   assign bus.req_ready    = w_go ? w_grant : '0;
   assign bus.mem_w_enable = w_wen;
   assign bus.mem_w_addr   = w_wen ? w_addr : '0;
   assign bus.mem_w_data   = w_wen ? w_wdata : '0;
   assign bus.mem_r_addr   = w_ren ? w_addr : '0;

   assign bus.resp_valid   = r_resp_valid;
   assign bus.resp_rdata   = r_resp_rdata;
   assign bus.resp_err     = r_resp_err;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_rr_ptr     <= '0;
         r_resp_valid <= '0;
         r_resp_rdata <= '0;
         r_resp_err   <= 1'b0;
      end else begin
         r_resp_valid <= '0;
         r_resp_err   <= 1'b0;
         if (w_any) begin
            r_rr_ptr   <= PW'(wrap_inc(32'(w_idx), n_req));
            r_resp_err <= ~w_in_range;
            if (!w_write) begin
               r_resp_valid <= w_grant;
               r_resp_rdata <= w_in_range ? bus.mem_r_data : '0;
            end
         end
      end
   end
endmodule

// File: tb/tb_mem_access_arbiter.sv
module tb_mem_access_arbiter;
   import mem_access_arbiter_pkg::*;

   localparam int W  = 32;
   localparam int L  = 10;
   localparam int N  = 2;
   localparam int AW = $clog2(L);

   typedef struct {
      logic          rst_n;
      logic [N-1:0]  valid;
      logic [N-1:0]  write;
      logic [AW-1:0] a0;
      logic [AW-1:0] a1;
      logic [W-1:0]  d0;
      logic [W-1:0]  d1;
      logic [N-1:0]  exp_ready;
      logic          exp_wen;
   } vec_t;

   typedef struct {
      logic [N-1:0] valid;
      logic [W-1:0] rdata;
      logic         err;
   } resp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   mem_access_arbiter_if #(.width(W), .length(L), .n_req(N), .addr_size(AW)) bus ();

   mem_access_arbiter #(.width(W), .length(L), .n_req(N), .addr_size(AW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // External memory: write on strobe, combinational read.
   logic [W-1:0] mem [L];
   always @(posedge clk)
      if (bus.mem_w_enable && int'(bus.mem_w_addr) < L)
         mem[int'(bus.mem_w_addr)] <= bus.mem_w_data;
   assign bus.mem_r_data = (int'(bus.mem_r_addr) < L) ? mem[int'(bus.mem_r_addr)] : '0;

   vec_t         vecs[$];
   resp_t        sb[$];
   logic [W-1:0] shadow [16];
   logic [W-1:0] exp_rdata = '0;
   int           n_vec  = 0;
   int           n_miss = 0;
   int           n_cmp  = 0;

   function automatic vec_t mk(input logic r, input logic [1:0] v, input logic [1:0] wr,
                               input int a0, input int a1, input logic [W-1:0] d0,
                               input logic [W-1:0] d1, input logic [1:0] er, input logic ew);
      vec_t t;
      t.rst_n = r; t.valid = v; t.write = wr;
      t.a0 = AW'(a0); t.a1 = AW'(a1); t.d0 = d0; t.d1 = d1;
      t.exp_ready = er; t.exp_wen = ew;
      return t;
   endfunction

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s (vector %0d): got %h, expected %h", name, n_vec, act, exp);
      end
   endtask

   // Expected response derived from the table's expected winner and a shadow memory.
   task automatic model_push(input vec_t v);
      resp_t         r;
      int            w;
      logic [AW-1:0] a;
      r.valid = '0;
      r.err   = 1'b0;
      if (!v.rst_n) begin
         exp_rdata = '0;
      end else if (v.exp_ready != '0) begin
         w = v.exp_ready[1] ? 1 : 0;
         a = (w == 1) ? v.a1 : v.a0;
         r.err = (int'(a) >= L);
         if (v.write[w]) begin
            if (int'(a) < L) shadow[int'(a)] = (w == 1) ? v.d1 : v.d0;
         end else begin
            r.valid   = v.exp_ready;
            exp_rdata = (int'(a) < L) ? shadow[int'(a)] : '0;
         end
      end
      r.rdata = exp_rdata;
      sb.push_back(r);
   endtask

   task automatic check_resp();
      resp_t r;
      if (sb.size() == 0) begin
         n_cmp++;
         n_miss++;
         $display("FAIL scoreboard_empty (vector %0d): got 0 entries, expected 1", n_vec);
      end else begin
         r = sb.pop_front();
         chk("resp_valid", W'(bus.resp_valid), W'(r.valid));
         chk("resp_rdata", bus.resp_rdata, r.rdata);
         chk("resp_err", W'(bus.resp_err), W'(r.err));
      end
   endtask

   task automatic drive(input vec_t v);
      rst_n          = v.rst_n;
      bus.req_valid  = v.valid;
      bus.req_write  = v.write;
      bus.req_addr   = {v.a1, v.a0};
      bus.req_wdata  = {v.d1, v.d0};
   endtask

   task automatic apply(input vec_t v);
      @(negedge clk);
      drive(v);
      n_vec++;
      #1;
      chk("req_ready", W'(bus.req_ready), W'(v.exp_ready));
      chk("mem_w_enable", W'(bus.mem_w_enable), W'(v.exp_wen));
      model_push(v);
      @(posedge clk);
      #1;
      check_resp();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected $finish");
      $fatal(1);
   end

   initial begin
      vec_t v;
      bus.req_valid = '0;
      bus.req_write = '0;
      bus.req_addr  = '0;
      bus.req_wdata = '0;
      repeat (2) @(posedge clk);

      //          rst  valid  write  a0  a1  d0            d1            ready  wen
      vecs.push_back(mk(0, 2'b11, 2'b00, 0,  0,  '0,           '0,           2'b00, 0));
      vecs.push_back(mk(0, 2'b11, 2'b11, 0,  0,  32'h1111_1111, 32'h2222_2222, 2'b00, 0));
      vecs.push_back(mk(1, 2'b11, 2'b11, 0,  1,  32'hA0A0_0000, 32'hB1B1_1111, 2'b01, 1));
      vecs.push_back(mk(1, 2'b11, 2'b11, 0,  1,  32'hA0A0_0000, 32'hB1B1_1111, 2'b10, 1));
      vecs.push_back(mk(1, 2'b01, 2'b01, 3,  0,  32'hDEAD_BEEF, '0,           2'b01, 1));
      vecs.push_back(mk(1, 2'b10, 2'b00, 0,  3,  '0,           '0,           2'b10, 0));
      for (int unsigned i = 0; i < 6; i++)
         vecs.push_back(mk(1, 2'b11, 2'b00, 0, 1, '0, '0, (i % 2 == 0) ? 2'b01 : 2'b10, 0));
      for (int unsigned i = 0; i < 3; i++)
         vecs.push_back(mk(1, 2'b10, 2'b00, 0, 1, '0, '0, 2'b10, 0));
      vecs.push_back(mk(1, 2'b11, 2'b00, 0,  1,  '0,           '0,           2'b01, 0));
      vecs.push_back(mk(1, 2'b00, 2'b00, 0,  1,  '0,           '0,           2'b00, 0));
      vecs.push_back(mk(1, 2'b11, 2'b00, 0,  1,  '0,           '0,           2'b10, 0));
      vecs.push_back(mk(1, 2'b01, 2'b01, 12, 0,  32'h0000_0055, '0,           2'b01, 0));
      vecs.push_back(mk(1, 2'b01, 2'b00, 12, 0,  '0,           '0,           2'b01, 0));

      foreach (vecs[i]) apply(vecs[i]);

      // Reset asserted while a read to requester 1 is being granted: no response.
      @(negedge clk);
      v = mk(1, 2'b10, 2'b00, 0, 3, '0, '0, 2'b10, 0);
      drive(v);
      n_vec++;
      #1;
      chk("ready_before_reset", W'(bus.req_ready), W'(2'b10));
      #2;
      rst_n = 1'b0;
      #1;
      chk("ready_in_reset", W'(bus.req_ready), W'(2'b00));
      chk("wen_in_reset", W'(bus.mem_w_enable), W'(1'b0));
      v.rst_n = 1'b0;
      v.exp_ready = 2'b00;
      model_push(v);
      @(posedge clk);
      #1;
      check_resp();

      // Pointer was 1 before reset; after release requester 0 must win.
      apply(mk(0, 2'b11, 2'b00, 3, 1, '0, '0, 2'b00, 0));
      apply(mk(1, 2'b11, 2'b00, 3, 1, '0, '0, 2'b01, 0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule
